// File: rtl/vec_pkg.sv
// Shared constants, state encoding and helpers for the vector command sequencer.
package vec_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int LANES    = 4;
  localparam int MAX_VL   = 32;
  localparam int VL_W     = $clog2(MAX_VL + 1);
  localparam int IMM_W    = 8;

  localparam logic [2:0] OP_VSETVLI = 3'd0;
  localparam logic [2:0] OP_VLOAD   = 3'd1;
  localparam logic [2:0] OP_VADDI   = 3'd2;
  localparam logic [2:0] OP_VACC    = 3'd3;
  localparam logic [2:0] OP_VMUL    = 3'd4;
  localparam logic [2:0] OP_VBACC   = 3'd5;
  localparam logic [2:0] OP_VSUBI   = 3'd6;

  localparam logic [1:0] BUS_LOAD = 2'b00;
  localparam logic [1:0] BUS_ALU  = 2'b01;
  localparam logic [1:0] BUS_MUL  = 2'b10;
  localparam logic [1:0] BUS_BACC = 2'b11;

  localparam logic [1:0] ALU_MODE_ADD = 2'b00;
  localparam logic [1:0] ALU_MODE_SUB = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

  // Decoded control fields for one command.
  typedef struct packed {
    logic       legal;
    logic       is_setvl;
    logic       use_op0;
    logic       op0_from_wb;
    logic       use_op1;
    logic       use_imm;
    logic       writes;
    logic [1:0] alu_mode;
    logic [1:0] bus_sel;
  } op_ctrl_t;

  // Register index step with wrap at the top of the register file.
  function automatic logic [REG_W-1:0] reg_inc(input logic [REG_W-1:0] r);
    if (r == REG_W'(NUM_REGS - 1)) return '0;
    return r + REG_W'(1);
  endfunction

  // Number of LANES-wide beats needed to cover len elements.
  function automatic logic [VL_W-1:0] beats_for(input logic [VL_W-1:0] len);
    logic [VL_W:0] sum;
    sum = {1'b0, len} + (VL_W+1)'(LANES - 1);
    return VL_W'(sum / (VL_W+1)'(LANES));
  endfunction

endpackage

// File: rtl/vec_op_decode.sv
// Pure combinational opcode to control-field / legality map.
module vec_op_decode
  import vec_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] reserved,
  output op_ctrl_t   ctrl
);

  // Map each opcode onto the operand usage and datapath routing it needs.
  always_comb begin
    ctrl = '0;
    if (reserved == 2'b00) begin
      unique case (opcode)
        OP_VSETVLI: begin
          ctrl.legal    = 1'b1;
          ctrl.is_setvl = 1'b1;
        end
        OP_VLOAD: begin
          ctrl.legal   = 1'b1;
          ctrl.writes  = 1'b1;
          ctrl.bus_sel = BUS_LOAD;
        end
        OP_VADDI, OP_VSUBI: begin
          ctrl.legal    = 1'b1;
          ctrl.use_op0  = 1'b1;
          ctrl.use_imm  = 1'b1;
          ctrl.writes   = 1'b1;
          ctrl.alu_mode = (opcode == OP_VSUBI) ? ALU_MODE_SUB : ALU_MODE_ADD;
          ctrl.bus_sel  = BUS_ALU;
        end
        OP_VACC: begin
          ctrl.legal   = 1'b1;
          ctrl.use_op0 = 1'b1;
          ctrl.writes  = 1'b1;
          ctrl.bus_sel = BUS_LOAD;
        end
        OP_VMUL: begin
          ctrl.legal   = 1'b1;
          ctrl.use_op0 = 1'b1;
          ctrl.use_op1 = 1'b1;
          ctrl.writes  = 1'b1;
          ctrl.bus_sel = BUS_MUL;
        end
        OP_VBACC: begin
          // Byte accumulate reads the register named in the wb field, never writes back.
          ctrl.legal       = 1'b1;
          ctrl.use_op0     = 1'b1;
          ctrl.op0_from_wb = 1'b1;
          ctrl.bus_sel     = BUS_BACC;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/vec_cmd_sequencer.sv
// Handshaked vector command sequencer: accepts one CFU command, issues one
// micro-op per register group, then returns a response.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | cmd_ready high, waiting for a command
//  ST_ISSUE | uop_valid high, stepping through beats (held by uop_stall)
//  ST_RESP  | rsp_valid high, payload/err held until rsp_ready
module vec_cmd_sequencer
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_payload_function_id,
  input  logic [31:0]      cmd_payload_inputs_0,
  input  logic [31:0]      cmd_payload_inputs_1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_payload_outputs_0,
  output logic             rsp_err,
  output logic             uop_valid,
  input  logic             uop_stall,
  output logic             uop_last,
  output logic [VL_W-1:0]  uop_beat,
  output logic [REG_W-1:0] reg_op0_sel,
  output logic [REG_W-1:0] reg_op1_sel,
  output logic [REG_W-1:0] reg_wb_sel,
  output logic             reg_load,
  output logic [IMM_W-1:0] alu_imm,
  output logic             alu_op1_sel,
  output logic [1:0]       alu_mode,
  output logic [1:0]       bus_sel,
  output logic [VL_W-1:0]  vl
);

  seq_state_e       state;
  op_ctrl_t         dec_ctrl;
  logic             accept;
  logic             use_op0_q;
  logic             use_op1_q;
  logic             writes_q;
  logic [VL_W-1:0]  nbeats_q;
  logic [VL_W-1:0]  cmd_nbeats;
  logic [VL_W-1:0]  vl_grant;
  logic [VL_W-1:0]  next_beat;
  logic [REG_W-1:0] wb_field;
  logic             unused_inputs;

  vec_op_decode u_decode (
    .opcode   (cmd_payload_function_id[2:0]),
    .reserved (cmd_payload_function_id[9:8]),
    .ctrl     (dec_ctrl)
  );

  assign accept        = cmd_valid & cmd_ready;
  assign wb_field      = cmd_payload_function_id[7:3];
  assign cmd_nbeats    = beats_for(vl);
  assign next_beat     = uop_beat + VL_W'(1);
  assign reg_load      = uop_valid & ~uop_stall & writes_q;
  assign unused_inputs = ^cmd_payload_inputs_1[31:IMM_W];

  // Clamp the requested vector length to the largest grantable value.
  always_comb begin
    if (cmd_payload_inputs_0 > 32'(MAX_VL)) vl_grant = VL_W'(MAX_VL);
    else                                    vl_grant = cmd_payload_inputs_0[VL_W-1:0];
  end

  // Sequencer FSM with registered handshake, micro-op and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= ST_IDLE;
      cmd_ready             <= 1'b1;
      rsp_valid             <= 1'b0;
      rsp_err               <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      vl                    <= '0;
      nbeats_q              <= '0;
      use_op0_q             <= 1'b0;
      use_op1_q             <= 1'b0;
      writes_q              <= 1'b0;
      uop_valid             <= 1'b0;
      uop_last              <= 1'b0;
      uop_beat              <= '0;
      reg_op0_sel           <= '0;
      reg_op1_sel           <= '0;
      reg_wb_sel            <= '0;
      alu_imm               <= '0;
      alu_op1_sel           <= 1'b0;
      alu_mode              <= '0;
      bus_sel               <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            if (!dec_ctrl.legal) begin
              state                 <= ST_RESP;
              rsp_valid             <= 1'b1;
              rsp_err               <= 1'b1;
              rsp_payload_outputs_0 <= '0;
            end else if (dec_ctrl.is_setvl) begin
              vl                    <= vl_grant;
              state                 <= ST_RESP;
              rsp_valid             <= 1'b1;
              rsp_err               <= 1'b0;
              rsp_payload_outputs_0 <= 32'(vl_grant);
            end else if (cmd_nbeats == '0) begin
              state                 <= ST_RESP;
              rsp_valid             <= 1'b1;
              rsp_err               <= 1'b0;
              rsp_payload_outputs_0 <= '0;
            end else begin
              state       <= ST_ISSUE;
              nbeats_q    <= cmd_nbeats;
              use_op0_q   <= dec_ctrl.use_op0;
              use_op1_q   <= dec_ctrl.use_op1;
              writes_q    <= dec_ctrl.writes;
              uop_valid   <= 1'b1;
              uop_beat    <= '0;
              uop_last    <= (cmd_nbeats == VL_W'(1));
              reg_op0_sel <= !dec_ctrl.use_op0 ? '0 :
                             dec_ctrl.op0_from_wb ? wb_field :
                             cmd_payload_inputs_0[REG_W-1:0];
              reg_op1_sel <= dec_ctrl.use_op1 ? cmd_payload_inputs_1[REG_W-1:0] : '0;
              reg_wb_sel  <= dec_ctrl.writes ? wb_field : '0;
              alu_imm     <= dec_ctrl.use_imm ? cmd_payload_inputs_1[IMM_W-1:0] : '0;
              alu_op1_sel <= dec_ctrl.use_imm;
              alu_mode    <= dec_ctrl.alu_mode;
              bus_sel     <= dec_ctrl.bus_sel;
            end
          end
        end
        ST_ISSUE: begin
          if (!uop_stall) begin
            if (uop_last) begin
              state                 <= ST_RESP;
              rsp_valid             <= 1'b1;
              rsp_err               <= 1'b0;
              rsp_payload_outputs_0 <= 32'(nbeats_q);
              writes_q              <= 1'b0;
              uop_valid             <= 1'b0;
              uop_last              <= 1'b0;
              uop_beat              <= '0;
              reg_op0_sel           <= '0;
              reg_op1_sel           <= '0;
              reg_wb_sel            <= '0;
              alu_imm               <= '0;
              alu_op1_sel           <= 1'b0;
              alu_mode              <= '0;
              bus_sel               <= '0;
            end else begin
              uop_beat <= next_beat;
              uop_last <= (next_beat == nbeats_q - VL_W'(1));
              if (use_op0_q) reg_op0_sel <= reg_inc(reg_op0_sel);
              if (use_op1_q) reg_op1_sel <= reg_inc(reg_op1_sel);
              if (writes_q)  reg_wb_sel  <= reg_inc(reg_wb_sel);
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state                 <= ST_IDLE;
            cmd_ready             <= 1'b1;
            rsp_valid             <= 1'b0;
            rsp_err               <= 1'b0;
            rsp_payload_outputs_0 <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_cmd_sequencer.sv
// Self-checking bench for vec_cmd_sequencer: directed table, corner sequences
// and randomized commands against a behavioural model.
module tb_vec_cmd_sequencer;

  localparam int M_NREGS  = 32;
  localparam int M_LANES  = 4;
  localparam int M_MAX_VL = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        rsp_err;
  logic        uop_valid;
  logic        uop_stall;
  logic        uop_last;
  logic [5:0]  uop_beat;
  logic [4:0]  reg_op0_sel;
  logic [4:0]  reg_op1_sel;
  logic [4:0]  reg_wb_sel;
  logic        reg_load;
  logic [7:0]  alu_imm;
  logic        alu_op1_sel;
  logic [1:0]  alu_mode;
  logic [1:0]  bus_sel;
  logic [5:0]  vl;

  int checks = 0;
  int errors = 0;
  int model_vl = 0;

  vec_cmd_sequencer dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .rsp_err                 (rsp_err),
    .uop_valid               (uop_valid),
    .uop_stall               (uop_stall),
    .uop_last                (uop_last),
    .uop_beat                (uop_beat),
    .reg_op0_sel             (reg_op0_sel),
    .reg_op1_sel             (reg_op1_sel),
    .reg_wb_sel              (reg_wb_sel),
    .reg_load                (reg_load),
    .alu_imm                 (alu_imm),
    .alu_op1_sel             (alu_op1_sel),
    .alu_mode                (alu_mode),
    .bus_sel                 (bus_sel),
    .vl                      (vl)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int op0;
    int op1;
    int wb;
    int imm;
    int op1sel;
    int mode;
    int bus;
    int writes;
  } beat_exp_t;

  function automatic int is_legal(input logic [9:0] fid);
    return (fid[9:8] == 2'b00 && fid[2:0] != 3'd7) ? 1 : 0;
  endfunction

  // Response and resulting vector length for a command given the current VL.
  function automatic void model_rsp(input logic [9:0] fid, input logic [31:0] in0, input int cur_vl,
                                    output int payload, output int err, output int new_vl);
    new_vl  = cur_vl;
    err     = 0;
    payload = 0;
    if (is_legal(fid) == 0) err = 1;
    else if (fid[2:0] == 3'd0) begin
      new_vl  = (in0 > 32'(M_MAX_VL)) ? M_MAX_VL : int'(in0);
      payload = new_vl;
    end else payload = (cur_vl + M_LANES - 1) / M_LANES;
  endfunction

  // Expected micro-op fields for beat b of an operation.
  function automatic beat_exp_t model_beat(input logic [9:0] fid, input logic [31:0] in0,
                                           input logic [31:0] in1, input int b);
    beat_exp_t e;
    int wbf, r0, r1;
    e = '{default: 0};
    wbf = int'(fid[7:3]);
    r0  = int'(in0[4:0]);
    r1  = int'(in1[4:0]);
    case (int'(fid[2:0]))
      1: begin e.wb = (wbf + b) % M_NREGS; e.writes = 1; e.bus = 0; end
      2, 6: begin
        e.op0 = (r0 + b) % M_NREGS; e.wb = (wbf + b) % M_NREGS; e.writes = 1;
        e.imm = int'(in1[7:0]); e.op1sel = 1; e.mode = (fid[2:0] == 3'd6) ? 1 : 0; e.bus = 1;
      end
      3: begin e.op0 = (r0 + b) % M_NREGS; e.wb = (wbf + b) % M_NREGS; e.writes = 1; e.bus = 0; end
      4: begin
        e.op0 = (r0 + b) % M_NREGS; e.op1 = (r1 + b) % M_NREGS;
        e.wb = (wbf + b) % M_NREGS; e.writes = 1; e.bus = 2;
      end
      5: begin e.op0 = (wbf + b) % M_NREGS; e.bus = 3; end
      default: ;
    endcase
    return e;
  endfunction

  // Issue one command from a negedge and follow it through beats and response.
  task automatic run_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1,
                         input int stall_beat, input int stall_len, input int stall_pct,
                         input int rsp_hold, input int exp_payload, input int exp_err,
                         input int exp_vl, input string tag);
    int nb, b, guard, stalled;
    logic stall;
    beat_exp_t e;
    nb = (is_legal(fid) != 0 && fid[2:0] != 3'd0) ? (model_vl + M_LANES - 1) / M_LANES : 0;
    chk({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0 = in0;
    cmd_payload_inputs_1 = in1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_payload_function_id = 10'($urandom);
    cmd_payload_inputs_0 = $urandom;
    cmd_payload_inputs_1 = $urandom;
    chk({tag, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
    b = 0; guard = 0; stalled = 0;
    while (b < nb && guard < 400) begin
      stall = ((b == stall_beat) && (stalled < stall_len)) || (int'($urandom_range(0, 99)) < stall_pct);
      if (stall && b == stall_beat) stalled++;
      uop_stall = stall;
      #1;
      e = model_beat(fid, in0, in1, b);
      chk({tag, ".uop_valid"}, 32'(uop_valid), 32'd1);
      chk({tag, ".uop_beat"}, 32'(uop_beat), 32'(b));
      chk({tag, ".uop_last"}, 32'(uop_last), 32'(b == nb - 1));
      chk({tag, ".op0_sel"}, 32'(reg_op0_sel), 32'(e.op0));
      chk({tag, ".op1_sel"}, 32'(reg_op1_sel), 32'(e.op1));
      chk({tag, ".wb_sel"}, 32'(reg_wb_sel), 32'(e.wb));
      chk({tag, ".alu_imm"}, 32'(alu_imm), 32'(e.imm));
      chk({tag, ".alu_op1_sel"}, 32'(alu_op1_sel), 32'(e.op1sel));
      chk({tag, ".alu_mode"}, 32'(alu_mode), 32'(e.mode));
      chk({tag, ".bus_sel"}, 32'(bus_sel), 32'(e.bus));
      chk({tag, ".reg_load"}, 32'(reg_load), 32'(e.writes != 0 && !stall));
      chk({tag, ".rsp_early"}, 32'(rsp_valid), 32'd0);
      if (!stall) b++;
      @(negedge clk);
      uop_stall = 1'b0;
      guard++;
    end
    if (b < nb) chk({tag, ".beat_timeout"}, 32'(b), 32'(nb));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_payload"}, rsp_payload_outputs_0, 32'(exp_payload));
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, ".uop_idle"}, 32'(uop_valid), 32'd0);
    chk({tag, ".fields_zero"}, 32'({reg_op0_sel, reg_wb_sel, bus_sel, alu_imm}), 32'd0);
    chk({tag, ".vl"}, 32'(vl), 32'(exp_vl));
    for (int i = 0; i < rsp_hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_payload"}, rsp_payload_outputs_0, 32'(exp_payload));
      chk({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".cmd_ready_again"}, 32'(cmd_ready), 32'd1);
    model_vl = exp_vl;
  endtask

  typedef struct {
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    int          stall_beat;
    int          stall_len;
    int          rsp_hold;
    int          exp_payload;
    int          exp_err;
    int          exp_vl;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int p, e, nv, op;
    logic [9:0] fid;
    logic [31:0] in0, in1;

    // fid encodings: {rsvd[1:0], wb[4:0], op[2:0]}
    tbl.push_back('{10'd25,  32'd0,   32'd0,    -1, 0, 0, 0, 0, 0,  "vload_vl0"});
    tbl.push_back('{10'd0,   32'd100, 32'd0,    -1, 0, 0, 32, 0, 32, "setvl_clamp"});
    tbl.push_back('{10'd7,   32'd3,   32'd3,    -1, 0, 0, 0, 1, 32, "illegal_op7"});
    tbl.push_back('{10'h201, 32'd0,   32'd0,    -1, 0, 0, 0, 1, 32, "illegal_rsvd"});
    tbl.push_back('{10'h100, 32'd5,   32'd0,    -1, 0, 0, 0, 1, 32, "setvl_rsvd"});
    tbl.push_back('{10'd75,  32'd20,  32'd0,    -1, 0, 1, 8, 0, 32, "vacc_vl32"});
    tbl.push_back('{10'd0,   32'd10,  32'd0,    -1, 0, 0, 10, 0, 10, "setvl_10"});
    tbl.push_back('{10'd42,  32'd2,   32'h7F,   -1, 0, 5, 3, 0, 10, "vaddi"});
    tbl.push_back('{10'd254, 32'd30,  32'h80,   -1, 0, 0, 3, 0, 10, "vsubi_wrap"});
    tbl.push_back('{10'd0,   32'd8,   32'd0,    -1, 0, 0, 8, 0, 8,  "setvl_8"});
    tbl.push_back('{10'd236, 32'd31,  32'd30,    1, 3, 0, 2, 0, 8,  "vmul_wrap_stall"});
    tbl.push_back('{10'd253, 32'd9,   32'd9,    -1, 0, 0, 2, 0, 8,  "vbacc"});
    tbl.push_back('{10'd0,   32'd0,   32'd0,    -1, 0, 0, 0, 0, 0,  "setvl_0"});
    tbl.push_back('{10'd236, 32'd1,   32'd2,    -1, 0, 0, 0, 0, 0,  "vmul_vl0"});
    tbl.push_back('{10'd0,   32'd1,   32'd0,    -1, 0, 0, 1, 0, 1,  "setvl_1"});
    tbl.push_back('{10'd33,  32'd0,   32'd0,    -1, 0, 0, 1, 0, 1,  "vload_1"});
    tbl.push_back('{10'd0,   32'd10,  32'd0,    -1, 0, 0, 10, 0, 10, "setvl_10b"});

    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    rsp_ready = 1'b0;
    uop_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset.uop_valid", 32'(uop_valid), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.vl", 32'(vl), 32'd0);
    chk("reset.payload", rsp_payload_outputs_0, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run_cmd(tbl[i].fid, tbl[i].in0, tbl[i].in1, tbl[i].stall_beat, tbl[i].stall_len, 0,
              tbl[i].rsp_hold, tbl[i].exp_payload, tbl[i].exp_err, tbl[i].exp_vl, tbl[i].name);

    // Reset in the middle of a 3-beat VADDI aborts it with no response.
    cmd_valid = 1'b1;
    cmd_payload_function_id = 10'd42;
    cmd_payload_inputs_0 = 32'd2;
    cmd_payload_inputs_1 = 32'h7F;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort.beat0", 32'(uop_beat), 32'd0);
    @(negedge clk);
    chk("abort.beat1_valid", 32'(uop_valid), 32'd1);
    chk("abort.beat1", 32'(uop_beat), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort.uop_valid", 32'(uop_valid), 32'd0);
    chk("abort.outs_zero", 32'({uop_beat, reg_op0_sel, reg_wb_sel, alu_imm, uop_last, reg_load}), 32'd0);
    chk("abort.vl", 32'(vl), 32'd0);
    chk("abort.cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort.after_ready", 32'(cmd_ready), 32'd1);
    chk("abort.after_rsp", 32'(rsp_valid), 32'd0);
    chk("abort.after_vl", 32'(vl), 32'd0);
    model_vl = 0;

    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 7));
      fid[9:8] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fid[7:3] = 5'($urandom);
      fid[2:0] = 3'(op);
      if (op == 0) in0 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      else in0 = $urandom;
      in1 = $urandom;
      model_rsp(fid, in0, model_vl, p, e, nv);
      run_cmd(fid, in0, in1, -1, 0, 25, int'($urandom_range(0, 3)), p, e, nv, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
